// File: rtl/alu_issue_scheduler_pkg.sv
// rtl/alu_issue_scheduler_pkg.sv - shared widths, opcode encodings and helpers for the ALU issue scheduler
package alu_issue_scheduler_pkg;

  localparam int unsigned ENTRIES_DEF = 8;
  localparam int unsigned ROB_W_DEF   = 4;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned OP_W_DEF    = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Opcode encodings shared with the ALU decoder
  localparam logic [OP_W_DEF-1:0] OP_ADD   = 6'd1;
  localparam logic [OP_W_DEF-1:0] OP_SUB   = 6'd2;
  localparam logic [OP_W_DEF-1:0] OP_AND   = 6'd3;
  localparam logic [OP_W_DEF-1:0] OP_OR    = 6'd4;
  localparam logic [OP_W_DEF-1:0] OP_XOR   = 6'd5;
  localparam logic [OP_W_DEF-1:0] OP_SLL   = 6'd6;
  localparam logic [OP_W_DEF-1:0] OP_SRL   = 6'd7;
  localparam logic [OP_W_DEF-1:0] OP_SLT   = 6'd8;
  localparam logic [OP_W_DEF-1:0] OP_BEQ   = 6'd16;
  localparam logic [OP_W_DEF-1:0] OP_JAL   = 6'd24;
  localparam logic [OP_W_DEF-1:0] OP_JALR  = 6'd25;
  localparam logic [OP_W_DEF-1:0] OP_LUI   = 6'd26;
  localparam logic [OP_W_DEF-1:0] OP_AUIPC = 6'd27;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_if.sv
// rtl/alu_issue_scheduler_if.sv - dispatch, broadcast and ALU issue bundle for the issue scheduler
interface alu_issue_scheduler_if
  import alu_issue_scheduler_pkg::*;
#(
  parameter int unsigned ROB_W  = ROB_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
);

  logic              disp_valid;
  logic [OP_W-1:0]   disp_op;
  logic [31:0]       disp_pc;
  logic [31:0]       disp_imm;
  logic [ROB_W-1:0]  disp_rd_rename;
  logic              disp_qj_busy;
  logic [ROB_W-1:0]  disp_qj;
  logic [DATA_W-1:0] disp_vj;
  logic              disp_qk_busy;
  logic [ROB_W-1:0]  disp_qk;
  logic [DATA_W-1:0] disp_vk;
  logic              rs_full;

  logic              alu_bc_valid;
  logic [ROB_W-1:0]  alu_bc_rename;
  logic [DATA_W-1:0] alu_bc_value;
  logic              lsb_bc_valid;
  logic [ROB_W-1:0]  lsb_bc_rename;
  logic [DATA_W-1:0] lsb_bc_value;

  logic              alu_enable;
  logic [OP_W-1:0]   alu_op;
  logic [31:0]       alu_pc;
  logic [31:0]       alu_imm;
  logic [DATA_W-1:0] alu_rs1;
  logic [DATA_W-1:0] alu_rs2;
  logic [ROB_W-1:0]  alu_rd_rename;

  modport master (
    output disp_valid, disp_op, disp_pc, disp_imm, disp_rd_rename,
           disp_qj_busy, disp_qj, disp_vj, disp_qk_busy, disp_qk, disp_vk,
           alu_bc_valid, alu_bc_rename, alu_bc_value,
           lsb_bc_valid, lsb_bc_rename, lsb_bc_value,
    input  rs_full, alu_enable, alu_op, alu_pc, alu_imm, alu_rs1, alu_rs2, alu_rd_rename
  );

  modport slave (
    input  disp_valid, disp_op, disp_pc, disp_imm, disp_rd_rename,
           disp_qj_busy, disp_qj, disp_vj, disp_qk_busy, disp_qk, disp_vk,
           alu_bc_valid, alu_bc_rename, alu_bc_value,
           lsb_bc_valid, lsb_bc_rename, lsb_bc_value,
    output rs_full, alu_enable, alu_op, alu_pc, alu_imm, alu_rs1, alu_rs2, alu_rd_rename
  );

endinterface

// File: rtl/alu_issue_picker.sv
// rtl/alu_issue_picker.sv - lowest-index priority encoder used for issue select and free-slot search
module alu_issue_picker #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest set bit is written last and wins
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// rtl/alu_issue_scheduler.sv - ALU reservation buffer: operand wakeup via broadcasts, one issue per cycle
module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEF,
  parameter int unsigned ROB_W   = ROB_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned OP_W    = OP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  alu_issue_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(ENTRIES);

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [ENTRIES-1:0] qj_busy_q, qj_busy_d;
  logic [ENTRIES-1:0] qk_busy_q, qk_busy_d;
  logic [OP_W-1:0]    op_q  [ENTRIES];
  logic [OP_W-1:0]    op_d  [ENTRIES];
  logic [31:0]        pc_q  [ENTRIES];
  logic [31:0]        pc_d  [ENTRIES];
  logic [31:0]        imm_q [ENTRIES];
  logic [31:0]        imm_d [ENTRIES];
  logic [ROB_W-1:0]   rd_q  [ENTRIES];
  logic [ROB_W-1:0]   rd_d  [ENTRIES];
  logic [ROB_W-1:0]   qj_q  [ENTRIES];
  logic [ROB_W-1:0]   qj_d  [ENTRIES];
  logic [ROB_W-1:0]   qk_q  [ENTRIES];
  logic [ROB_W-1:0]   qk_d  [ENTRIES];
  logic [DATA_W-1:0]  vj_q  [ENTRIES];
  logic [DATA_W-1:0]  vj_d  [ENTRIES];
  logic [DATA_W-1:0]  vk_q  [ENTRIES];
  logic [DATA_W-1:0]  vk_d  [ENTRIES];

  logic              en_q, en_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic [31:0]       out_imm_q, out_imm_d;
  logic [DATA_W-1:0] out_rs1_q, out_rs1_d;
  logic [DATA_W-1:0] out_rs2_q, out_rs2_d;
  logic [ROB_W-1:0]  out_rd_q, out_rd_d;

  logic [ENTRIES-1:0] ready;
  logic [IDX_W-1:0]   issue_idx, free_idx;
  logic               issue_found, free_found;
  logic               full;

  assign ready = busy_q & ~qj_busy_q & ~qk_busy_q;
  assign full  = &busy_q;

  alu_issue_picker #(.N(ENTRIES), .IDX_W(IDX_W)) u_issue_pick (
    .req_i   (ready),
    .idx_o   (issue_idx),
    .found_o (issue_found)
  );

  alu_issue_picker #(.N(ENTRIES), .IDX_W(IDX_W)) u_free_pick (
    .req_i   (~busy_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  always_comb begin
    busy_d    = busy_q;
    qj_busy_d = qj_busy_q;
    qk_busy_d = qk_busy_q;
    op_d      = op_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    vj_d      = vj_q;
    vk_d      = vk_q;
    en_d      = en_q;
    out_op_d  = out_op_q;
    out_pc_d  = out_pc_q;
    out_imm_d = out_imm_q;
    out_rs1_d = out_rs1_q;
    out_rs2_d = out_rs2_q;
    out_rd_d  = out_rd_q;

    if (rollback) begin
      busy_d = '0;
      en_d   = FALSE;
    end else begin
      // Wakeup: ALU broadcast takes precedence over LSB
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy_q[i] && qj_busy_q[i]) begin
          if (bus.alu_bc_valid && bus.alu_bc_rename == qj_q[i]) begin
            vj_d[i]      = bus.alu_bc_value;
            qj_busy_d[i] = FALSE;
          end else if (bus.lsb_bc_valid && bus.lsb_bc_rename == qj_q[i]) begin
            vj_d[i]      = bus.lsb_bc_value;
            qj_busy_d[i] = FALSE;
          end
        end
        if (busy_q[i] && qk_busy_q[i]) begin
          if (bus.alu_bc_valid && bus.alu_bc_rename == qk_q[i]) begin
            vk_d[i]      = bus.alu_bc_value;
            qk_busy_d[i] = FALSE;
          end else if (bus.lsb_bc_valid && bus.lsb_bc_rename == qk_q[i]) begin
            vk_d[i]      = bus.lsb_bc_value;
            qk_busy_d[i] = FALSE;
          end
        end
      end

      if (issue_found) begin
        busy_d[issue_idx] = FALSE;
        en_d              = TRUE;
        out_op_d          = op_q[issue_idx];
        out_pc_d          = pc_q[issue_idx];
        out_imm_d         = imm_q[issue_idx];
        out_rs1_d         = vj_q[issue_idx];
        out_rs2_d         = vk_q[issue_idx];
        out_rd_d          = rd_q[issue_idx];
      end else begin
        en_d = FALSE;
      end

      // The free slot comes from pre-edge busy bits, so it never collides with the issuing slot
      if (bus.disp_valid && !full && free_found) begin
        busy_d[free_idx]    = TRUE;
        op_d[free_idx]      = bus.disp_op;
        pc_d[free_idx]      = bus.disp_pc;
        imm_d[free_idx]     = bus.disp_imm;
        rd_d[free_idx]      = bus.disp_rd_rename;
        qj_d[free_idx]      = bus.disp_qj;
        qk_d[free_idx]      = bus.disp_qk;
        vj_d[free_idx]      = bus.disp_vj;
        vk_d[free_idx]      = bus.disp_vk;
        qj_busy_d[free_idx] = bus.disp_qj_busy;
        qk_busy_d[free_idx] = bus.disp_qk_busy;
        if (bus.disp_qj_busy) begin
          if (bus.alu_bc_valid && bus.alu_bc_rename == bus.disp_qj) begin
            vj_d[free_idx]      = bus.alu_bc_value;
            qj_busy_d[free_idx] = FALSE;
          end else if (bus.lsb_bc_valid && bus.lsb_bc_rename == bus.disp_qj) begin
            vj_d[free_idx]      = bus.lsb_bc_value;
            qj_busy_d[free_idx] = FALSE;
          end
        end
        if (bus.disp_qk_busy) begin
          if (bus.alu_bc_valid && bus.alu_bc_rename == bus.disp_qk) begin
            vk_d[free_idx]      = bus.alu_bc_value;
            qk_busy_d[free_idx] = FALSE;
          end else if (bus.lsb_bc_valid && bus.lsb_bc_rename == bus.disp_qk) begin
            vk_d[free_idx]      = bus.lsb_bc_value;
            qk_busy_d[free_idx] = FALSE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      qj_busy_q <= '0;
      qk_busy_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]  <= '0;
        pc_q[i]  <= '0;
        imm_q[i] <= '0;
        rd_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
      end
      en_q      <= FALSE;
      out_op_q  <= '0;
      out_pc_q  <= '0;
      out_imm_q <= '0;
      out_rs1_q <= '0;
      out_rs2_q <= '0;
      out_rd_q  <= '0;
    end else if (rdy) begin
      busy_q    <= busy_d;
      qj_busy_q <= qj_busy_d;
      qk_busy_q <= qk_busy_d;
      op_q      <= op_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      qj_q      <= qj_d;
      qk_q      <= qk_d;
      vj_q      <= vj_d;
      vk_q      <= vk_d;
      en_q      <= en_d;
      out_op_q  <= out_op_d;
      out_pc_q  <= out_pc_d;
      out_imm_q <= out_imm_d;
      out_rs1_q <= out_rs1_d;
      out_rs2_q <= out_rs2_d;
      out_rd_q  <= out_rd_d;
    end
  end

  assign bus.rs_full       = full;
  assign bus.alu_enable    = en_q;
  assign bus.alu_op        = out_op_q;
  assign bus.alu_pc        = out_pc_q;
  assign bus.alu_imm       = out_imm_q;
  assign bus.alu_rs1       = out_rs1_q;
  assign bus.alu_rs2       = out_rs2_q;
  assign bus.alu_rd_rename = out_rd_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb/tb_alu_issue_scheduler.sv - scoreboard bench for the ALU issue scheduler
module tb_alu_issue_scheduler;
  import alu_issue_scheduler_pkg::*;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  rd;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rst, rdy, rollback;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_issue_scheduler_if #(.ROB_W(4), .DATA_W(32), .OP_W(6)) bus ();

  alu_issue_scheduler #(.ENTRIES(8), .ROB_W(4), .DATA_W(32), .OP_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [3:0] rd, input logic qjb, input logic [3:0] qj,
                      input logic [31:0] vj, input logic qkb, input logic [3:0] qk,
                      input logic [31:0] vk);
    bus.disp_valid     = 1'b1;
    bus.disp_op        = op;
    bus.disp_pc        = pc;
    bus.disp_imm       = imm;
    bus.disp_rd_rename = rd;
    bus.disp_qj_busy   = qjb;
    bus.disp_qj        = qj;
    bus.disp_vj        = vj;
    bus.disp_qk_busy   = qkb;
    bus.disp_qk        = qk;
    bus.disp_vk        = vk;
  endtask

  task automatic expect_issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [3:0] rd, input int at);
    exp_t e;
    e.op = op; e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.at = at;
    sb.push_back(e);
  endtask

  task automatic quiet();
    bus.disp_valid   = 1'b0;
    bus.alu_bc_valid = 1'b0;
    bus.lsb_bc_valid = 1'b0;
  endtask

  // The ALU consumes an issue on every edge where both alu_enable and rdy are high
  always @(negedge clk) begin
    if (!rst && bus.alu_enable && rdy) begin
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_issue", bus.alu_rd_rename, 0);
      end else begin
        mon_e = sb.pop_front();
        check(bus.alu_rd_rename == mon_e.rd, "issue_rd", bus.alu_rd_rename, mon_e.rd);
        check(bus.alu_op == mon_e.op, "issue_op", bus.alu_op, mon_e.op);
        check(bus.alu_pc == mon_e.pc, "issue_pc", bus.alu_pc, mon_e.pc);
        check(bus.alu_imm == mon_e.imm, "issue_imm", bus.alu_imm, mon_e.imm);
        check(bus.alu_rs1 == mon_e.rs1, "issue_rs1", bus.alu_rs1, mon_e.rs1);
        check(bus.alu_rs2 == mon_e.rs2, "issue_rs2", bus.alu_rs2, mon_e.rs2);
        check(cyc == mon_e.at, "issue_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    quiet();
    disp(6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.disp_valid    = 1'b0;
    bus.alu_bc_rename = '0; bus.alu_bc_value = '0;
    bus.lsb_bc_rename = '0; bus.lsb_bc_value = '0;
    repeat (3) tick();
    check(bus.rs_full == 1'b0, "reset_rs_full", bus.rs_full, 0);
    check(bus.alu_enable == 1'b0, "reset_enable", bus.alu_enable, 0);
    check(bus.alu_rs1 == 32'd0, "reset_rs1", bus.alu_rs1, 0);
    check(bus.alu_op == 6'd0, "reset_op", bus.alu_op, 0);
    check(bus.alu_rd_rename == 4'd0, "reset_rd", bus.alu_rd_rename, 0);
    rst = 1'b0;
    tick();

    // ADD, both operands known: issue two cycles after dispatch
    disp(OP_ADD, 32'h100, 32'h0, 4'd3, 0, 0, 32'd5, 0, 0, 32'd7);
    expect_issue(OP_ADD, 32'h100, 32'h0, 32'd5, 32'd7, 4'd3, cyc + 2);
    tick(); quiet();
    tick();
    tick();
    check(bus.alu_enable == 1'b0, "add_enable_drop", bus.alu_enable, 0);

    // SUB waiting on tag 2, woken by ALU broadcast three cycles later
    disp(OP_SUB, 32'h104, 32'h0, 4'd6, 1, 4'd2, 32'hDEAD, 0, 0, 32'd1);
    tick(); quiet();
    tick();
    tick();
    check(bus.alu_enable == 1'b0, "sub_waits", bus.alu_enable, 0);
    bus.alu_bc_valid = 1'b1; bus.alu_bc_rename = 4'd2; bus.alu_bc_value = 32'h10;
    expect_issue(OP_SUB, 32'h104, 32'h0, 32'h10, 32'd1, 4'd6, cyc + 2);
    tick(); quiet();
    repeat (3) tick();

    // Same-cycle LSB broadcast bypassed into a dispatched pending rs2
    disp(OP_AND, 32'h108, 32'h4, 4'd7, 0, 0, 32'h0F0F, 1, 4'd5, 32'h1111);
    bus.lsb_bc_valid = 1'b1; bus.lsb_bc_rename = 4'd5; bus.lsb_bc_value = 32'hABCD;
    expect_issue(OP_AND, 32'h108, 32'h4, 32'h0F0F, 32'hABCD, 4'd7, cyc + 2);
    tick(); quiet();
    repeat (3) tick();

    // Fill all eight slots with pending entries, then drop a ninth
    for (int i = 0; i < 8; i++) begin
      disp(OP_OR, 32'h200 + 32'(4 * i), 32'(i), 4'(i), 1, 4'(8 + i), 32'd0, 0, 0, 32'h44);
      tick();
    end
    check(bus.rs_full == 1'b1, "full_after_8", bus.rs_full, 1);
    disp(OP_ADD, 32'h300, 32'h0, 4'd9, 0, 0, 32'd1, 0, 0, 32'd2);
    tick(); quiet();
    check(bus.rs_full == 1'b1, "full_holds", bus.rs_full, 1);
    bus.alu_bc_valid = 1'b1; bus.alu_bc_rename = 4'd12; bus.alu_bc_value = 32'h44;
    expect_issue(OP_OR, 32'h210, 32'h4, 32'h44, 32'h44, 4'd4, cyc + 2);
    tick(); quiet();
    check(bus.rs_full == 1'b1, "full_before_issue", bus.rs_full, 1);
    tick();
    check(bus.rs_full == 1'b0, "full_drops_after_issue", bus.rs_full, 0);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    check(bus.rs_full == 1'b0, "rollback_clears", bus.rs_full, 0);
    check(bus.alu_enable == 1'b0, "rollback_enable", bus.alu_enable, 0);

    // Slots 1 and 6 become ready together: lower index first
    for (int i = 0; i < 8; i++) begin
      disp(OP_XOR, 32'h500 + 32'(4 * i), 32'h0, 4'(i), 1, 4'(8 + i), 32'd0, 0, 0, 32'(i));
      tick();
    end
    quiet();
    bus.alu_bc_valid = 1'b1; bus.alu_bc_rename = 4'd9;  bus.alu_bc_value = 32'h91;
    bus.lsb_bc_valid = 1'b1; bus.lsb_bc_rename = 4'd14; bus.lsb_bc_value = 32'hE6;
    expect_issue(OP_XOR, 32'h504, 32'h0, 32'h91, 32'd1, 4'd1, cyc + 2);
    expect_issue(OP_XOR, 32'h518, 32'h0, 32'hE6, 32'd6, 4'd6, cyc + 3);
    tick(); quiet();
    repeat (3) tick();
    check(bus.alu_enable == 1'b0, "pick_done", bus.alu_enable, 0);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;

    // Rollback while a woken entry is about to issue, with a same-cycle dispatch
    for (int i = 0; i < 3; i++) begin
      disp(OP_ADD, 32'h600 + 32'(4 * i), 32'h0, 4'(10 + i), 1, 4'(1 + i), 32'd0, 0, 0, 32'd0);
      tick();
    end
    quiet();
    check(bus.rs_full == 1'b0, "three_busy_not_full", bus.rs_full, 0);
    bus.alu_bc_valid = 1'b1; bus.alu_bc_rename = 4'd2; bus.alu_bc_value = 32'h22;
    tick(); quiet();
    rollback = 1'b1;
    disp(OP_ADD, 32'h700, 32'h0, 4'd15, 0, 0, 32'd1, 0, 0, 32'd1);
    tick();
    rollback = 1'b0; quiet();
    check(bus.rs_full == 1'b0, "rollback3_full", bus.rs_full, 0);
    check(bus.alu_enable == 1'b0, "rollback3_enable", bus.alu_enable, 0);
    repeat (4) tick();

    // Freeze with an issue on the output; a held dispatch is only taken after rdy returns
    disp(OP_ADD, 32'h400, 32'h8, 4'd13, 0, 0, 32'h55, 0, 0, 32'h66);
    expect_issue(OP_ADD, 32'h400, 32'h8, 32'h55, 32'h66, 4'd13, cyc + 5);
    expect_issue(OP_SLT, 32'h404, 32'h0, 32'h77, 32'h88, 4'd14, cyc + 7);
    tick(); quiet();
    tick();
    rdy = 1'b0;
    disp(OP_SLT, 32'h404, 32'h0, 4'd14, 0, 0, 32'h77, 0, 0, 32'h88);
    for (int i = 0; i < 3; i++) begin
      tick();
      check(bus.alu_enable == 1'b1, "freeze_enable", bus.alu_enable, 1);
      check(bus.alu_rs1 == 32'h55, "freeze_rs1", bus.alu_rs1, 32'h55);
    end
    rdy = 1'b1;
    tick(); quiet();
    check(bus.alu_enable == 1'b0, "single_consume", bus.alu_enable, 0);
    repeat (3) tick();

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
Buffers decoded ALU-class instructions (arithmetic, logic, shifts, compares, branches, JAL/JALR, LUI/AUIPC) until both source operands are known. Snoops the ALU and LSB result broadcasts to wake waiting operands. Each cycle it issues at most one ready entry to the single ALU, driving the ALU's enable/operand inputs. Sits between the dispatcher/ROB rename stage and the ALU.

Parameters:
ENTRIES, 8, number of buffer slots (power of two, 2..16)
ROB_W, 4, rename tag width (ROB index)
DATA_W, 32, operand/result width
OP_W, 6, internal opcode width (same encoding the ALU decodes)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = freeze
rollback  in  1  misprediction flush, sampled when rdy=1
disp_valid  in  1  dispatcher offers an instruction
disp_op  in  OP_W  opcode
disp_pc  in  32  instruction PC
disp_imm  in  32  sign-extended immediate
disp_rd_rename  in  ROB_W  destination ROB tag
disp_qj_busy  in  1  rs1 pending (value not yet known)
disp_qj  in  ROB_W  rs1 producer tag
disp_vj  in  DATA_W  rs1 value if not pending
disp_qk_busy  in  1  rs2 pending
disp_qk  in  ROB_W  rs2 producer tag
disp_vk  in  DATA_W  rs2 value if not pending
rs_full  out  1  no free slot (combinational from registered busy bits)
alu_bc_valid  in  1  ALU broadcast valid
alu_bc_rename  in  ROB_W  ALU broadcast tag
alu_bc_value  in  DATA_W  ALU broadcast result
lsb_bc_valid  in  1  LSB broadcast valid
lsb_bc_rename  in  ROB_W  LSB broadcast tag
lsb_bc_value  in  DATA_W  LSB broadcast result
alu_enable  out  1  issue strobe to ALU (registered)
alu_op  out  OP_W  issued opcode
alu_pc  out  32  issued PC
alu_imm  out  32  issued immediate
alu_rs1  out  DATA_W  issued rs1 value
alu_rs2  out  DATA_W  issued rs2 value
alu_rd_rename  out  ROB_W  issued destination tag

Behaviour:
- Reset (rst=1 at posedge): all busy bits 0; alu_enable=0; all other outputs 0. Reset wins over rollback and rdy.
- rdy=0: no state change; all outputs hold (ALU ignores a held alu_enable until rdy returns, then consumes it exactly once).
- rollback=1 (rdy=1): all busy bits cleared, alu_enable<=0; same-cycle dispatch and issue discarded.
- Accept: disp_valid && !rs_full -> write lowest-index free slot. Dispatch while rs_full is dropped; dispatcher must hold.
- Dispatch bypass: if operand pending and its tag matches a same-cycle valid broadcast (ALU checked before LSB; both matching is illegal), store the broadcast value as ready.
- Wakeup: every busy slot compares pending qj/qk against both broadcasts each cycle; on match capture value, clear pending. Woken entry eligible next cycle (no same-cycle wake-and-issue).
- Ready = busy && !qj_busy && !qk_busy, evaluated on registered state.
- Issue: lowest-index ready slot selected; at posedge alu_enable<=1, operands/op/pc/imm/tag registered, slot busy cleared. No ready slot -> alu_enable<=0. Issue latency: 1 cycle from ready to alu_enable; minimum dispatch-to-issue is 2 cycles.
- Simultaneous dispatch + issue: both happen; freed slot reusable the following cycle only. rs_full from pre-edge busy bits, so full stays asserted the cycle an issue frees a slot.
- Ops with no register sources (LUI, AUIPC, JAL) dispatched with both busy=0; scheduler does not decode op.

Decomposition:
- Shared package/define file: OP_W opcode encodings, ROB_W/DATA_W widths, TRUE/FALSE constants (existing define file).
- Sub-module: alu_issue_picker — combinational lowest-index priority encoder (ready vector -> index + found), reused for free-slot search.

Test Plan:
- Reset then ADD (tag 3, vj=5, vk=7, none pending) -> alu_enable=1 two cycles after dispatch, alu_rs1=5, alu_rs2=7, alu_rd_rename=3; next cycle alu_enable=0.
- SUB with qj=tag 2 pending; ALU broadcasts tag 2 value 0x10 three cycles later -> issue one cycle after broadcast with alu_rs1=0x10.
- Dispatch with qk=tag 5 in same cycle LSB broadcasts tag 5 value 0xABCD -> bypass captured, issue with alu_rs2=0xABCD without further broadcast.
- Fill 8 entries all pending -> rs_full=1, 9th dispatch dropped; wake slot 4 -> issues slot 4; rs_full drops the cycle after issue.
- Slots 1 and 6 ready together -> slot 1 issued first, slot 6 next cycle.
- rollback with 3 busy entries and rdy=1 -> next cycle rs_full=0, alu_enable=0, no stale issue; rdy=0 mid-sequence -> outputs frozen, resume unchanged.
